tone_arbiter: RTL and testbench

Parametrised multi-channel square-wave generator and priority arbiter that drives the single piezo pin. It replaces the fixed horn/click/melody/engine tone logic with `NUM_CH` identical channels. Each channel has a runtime period, duty, and mode. Each channel runs either as a level-held tone or as a retriggerable one-shot burst of programmable length. Upstream controllers (horn, turn-signal click, reverse melody sequencer, engine RPM mapper) each own one channel. Channel 0 has the highest priority.

---
 rtl/tone_arbiter.sv | 146 ++++++++++++++
 tb/tb_tone_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_arbiter.sv
// tone_arbiter: NUM_CH square-wave channels (level tone or retriggerable one-shot
// burst) with fixed-priority arbitration onto a single registered piezo pin.
module tone_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 20,
  parameter int DUR_W    = 24
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic [NUM_CH-1:0]            ch_trig,
  input  logic [NUM_CH-1:0]            ch_oneshot,
  input  logic [NUM_CH*PERIOD_W-1:0]   ch_period,
  input  logic [NUM_CH*3-1:0]          ch_duty,
  input  logic [NUM_CH*DUR_W-1:0]      ch_dur,
  input  logic                         mute,
  output logic                         piezo_out,
  output logic                         any_active,
  output logic [$clog2(NUM_CH)-1:0]    active_ch
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [PERIOD_W-1:0] PER_ZERO = {PERIOD_W{1'b0}};
  localparam logic [PERIOD_W-1:0] PER_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};
  localparam logic [PERIOD_W-1:0] PER_TWO  = {{(PERIOD_W-2){1'b0}}, 2'b10};
  localparam logic [DUR_W-1:0]    DUR_ZERO = {DUR_W{1'b0}};
  localparam logic [DUR_W-1:0]    DUR_ONE  = {{(DUR_W-1){1'b0}}, 1'b1};

  logic [NUM_CH-1:0] act_r;
  logic [NUM_CH-1:0] act_nxt_s;
  logic [NUM_CH-1:0] wave_s;
  logic [CH_W-1:0]   win_s;
  logic              win_wave_s;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [PERIOD_W-1:0] period_s;
    logic [DUR_W-1:0]    dur_s;
    logic [2:0]          duty_s;
    logic [PERIOD_W-1:0] cnt_r, cnt_nxt_s;
    logic [PERIOD_W-1:0] p_lat_r, p_lat_nxt_s;
    logic [PERIOD_W-1:0] high_s;
    logic [DUR_W-1:0]    dur_cnt_r, dur_cnt_nxt_s;
    logic                act_s;
    logic                wrap_s;

    assign period_s = ch_period[g*PERIOD_W +: PERIOD_W];
    assign dur_s    = ch_dur[g*DUR_W +: DUR_W];
    assign duty_s   = ch_duty[g*3 +: 3];

    // Activity: level-held in tone mode, down-counting burst in one-shot mode.
    always_comb begin
      dur_cnt_nxt_s = DUR_ZERO;
      act_s         = 1'b0;
      if (ch_oneshot[g]) begin
        if (ch_trig[g] && (dur_s != DUR_ZERO)) begin
          dur_cnt_nxt_s = dur_s;
        end else if (dur_cnt_r != DUR_ZERO) begin
          dur_cnt_nxt_s = dur_cnt_r - DUR_ONE;
        end else begin
          dur_cnt_nxt_s = DUR_ZERO;
        end
        act_s = (dur_cnt_nxt_s != DUR_ZERO);
      end else begin
        dur_cnt_nxt_s = DUR_ZERO;
        act_s         = ch_en[g];
      end
    end

    assign act_nxt_s[g] = act_s;
    assign wrap_s = ({1'b0, cnt_r} + {1'b0, PER_ONE}) >= {1'b0, p_lat_r};

    // Phase counter; the period is only re-latched at start or at a wrap.
    always_comb begin
      cnt_nxt_s   = PER_ZERO;
      p_lat_nxt_s = p_lat_r;
      if (act_s) begin
        if (!act_r[g] || wrap_s) begin
          cnt_nxt_s   = PER_ZERO;
          p_lat_nxt_s = period_s;
        end else begin
          cnt_nxt_s   = cnt_r + PER_ONE;
          p_lat_nxt_s = p_lat_r;
        end
      end else begin
        cnt_nxt_s   = PER_ZERO;
        p_lat_nxt_s = p_lat_r;
      end
    end

    // Per-channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r     <= PER_ZERO;
        p_lat_r   <= PER_ZERO;
        dur_cnt_r <= DUR_ZERO;
      end else begin
        cnt_r     <= cnt_nxt_s;
        p_lat_r   <= p_lat_nxt_s;
        dur_cnt_r <= dur_cnt_nxt_s;
      end
    end

    // Duty code is applied live; a zero-length high time never drives high.
    assign high_s    = p_lat_r >> ({1'b0, duty_s} + 4'd1);
    assign wave_s[g] = act_r[g] && (p_lat_r >= PER_TWO) && (duty_s != 3'd7) &&
                       (cnt_r < high_s);
  end

  // Active flags for all channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_r <= {NUM_CH{1'b0}};
    end else begin
      act_r <= act_nxt_s;
    end
  end

  // Lowest-index active channel wins, even when its own wave is silent.
  always_comb begin
    win_s      = {CH_W{1'b0}};
    win_wave_s = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (act_r[i]) begin
        win_s      = CH_W'(i);
        win_wave_s = wave_s[i];
      end else begin
        win_s      = win_s;
        win_wave_s = win_wave_s;
      end
    end
  end

  // Registered pin and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      piezo_out  <= 1'b0;
      any_active <= 1'b0;
      active_ch  <= {CH_W{1'b0}};
    end else begin
      piezo_out  <= win_wave_s & ~mute;
      any_active <= |act_r;
      active_ch  <= win_s;
    end
  end

endmodule

// File: tb/tb_tone_arbiter.sv
// Directed self-checking bench for tone_arbiter: tone, one-shot, priority,
// period change, silent winner, mute and asynchronous reset.
module tb_tone_arbiter;

  localparam int NUM_CH   = 4;
  localparam int PERIOD_W = 20;
  localparam int DUR_W    = 24;
  localparam int CH_W     = $clog2(NUM_CH);

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [NUM_CH-1:0]          ch_en = '0;
  logic [NUM_CH-1:0]          ch_trig = '0;
  logic [NUM_CH-1:0]          ch_oneshot = '0;
  logic [NUM_CH*PERIOD_W-1:0] ch_period = '0;
  logic [NUM_CH*3-1:0]        ch_duty = '0;
  logic [NUM_CH*DUR_W-1:0]    ch_dur = '0;
  logic                       mute = 1'b0;
  logic                       piezo_out;
  logic                       any_active;
  logic [CH_W-1:0]            active_ch;

  int tests = 0;
  int fails = 0;

  tone_arbiter #(.NUM_CH(NUM_CH), .PERIOD_W(PERIOD_W), .DUR_W(DUR_W)) dut (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .ch_trig(ch_trig),
    .ch_oneshot(ch_oneshot), .ch_period(ch_period), .ch_duty(ch_duty),
    .ch_dur(ch_dur), .mute(mute), .piezo_out(piezo_out),
    .any_active(any_active), .active_ch(active_ch)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ch(input int c, input int per, input int k, input int dur, input logic os);
    ch_period[c*PERIOD_W +: PERIOD_W] = PERIOD_W'(per);
    ch_duty[c*3 +: 3]                 = 3'(k);
    ch_dur[c*DUR_W +: DUR_W]          = DUR_W'(dur);
    ch_oneshot[c]                     = os;
  endtask

  initial begin
    logic [31:0] pat;
    int na;
    int np;

    // Reset state
    cyc(2);
    chk("rst_piezo", 32'(piezo_out), 32'd0);
    chk("rst_any", 32'(any_active), 32'd0);
    chk("rst_ch", 32'(active_ch), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // Ch1 tone, period 8, k=0
    set_ch(1, 8, 0, 0, 1'b0);
    ch_en[1] = 1'b1;
    cyc(1);
    chk("t1_lat_piezo", 32'(piezo_out), 32'd0);
    chk("t1_lat_any", 32'(any_active), 32'd0);
    cyc(1);
    chk("t1_any", 32'(any_active), 32'd1);
    chk("t1_ch", 32'(active_ch), 32'd1);
    pat = 32'd0;
    for (int i = 0; i < 16; i++) begin
      pat = {pat[30:0], piezo_out};
      cyc(1);
    end
    chk("t1_pattern", pat, 32'h0000_F0F0);
    ch_en[1] = 1'b0;
    cyc(1);
    chk("t1_drop_lat", 32'(any_active), 32'd1);
    cyc(1);
    chk("t1_drop", 32'(any_active), 32'd0);
    cyc(3);

    // Ch2 one-shot, period 10, k=2, 25 cycles
    set_ch(2, 10, 2, 25, 1'b1);
    ch_trig[2] = 1'b1;
    cyc(1);
    na = 0; np = 0;
    for (int i = 0; i < 40; i++) begin
      if (any_active === 1'b1) na++;
      if (piezo_out === 1'b1) np++;
      if (i == 1) chk("t2_ch", 32'(active_ch), 32'd2);
      ch_trig[2] = 1'b0;
      cyc(1);
    end
    chk("t2_active_cycles", 32'(na), 32'd25);
    chk("t2_high_cycles", 32'(np), 32'd3);

    // Retrigger after 23 active cycles: 23 + 25 active, phase not reset
    ch_trig[2] = 1'b1;
    cyc(1);
    na = 0; np = 0;
    for (int i = 0; i < 60; i++) begin
      if (any_active === 1'b1) na++;
      if (piezo_out === 1'b1) np++;
      ch_trig[2] = (i == 22);
      cyc(1);
    end
    chk("t2_retrig_active", 32'(na), 32'd48);
    chk("t2_retrig_high", 32'(np), 32'd5);

    // Zero-length trigger and trigger in tone mode are ignored
    set_ch(2, 10, 2, 0, 1'b1);
    ch_trig[2] = 1'b1;
    cyc(1);
    ch_trig[2] = 1'b0;
    cyc(2);
    chk("t2_dur0_ignored", 32'(any_active), 32'd0);
    set_ch(2, 10, 2, 25, 1'b0);
    ch_trig[2] = 1'b1;
    cyc(1);
    ch_trig[2] = 1'b0;
    cyc(2);
    chk("t2_tone_trig_ignored", 32'(any_active), 32'd0);

    // Ch3 tone period 8 running; ch0 tone period 6 preempts for 30 cycles
    set_ch(3, 8, 0, 0, 1'b0);
    set_ch(0, 6, 0, 0, 1'b0);
    ch_en[3] = 1'b1;
    cyc(6);
    ch_en[0] = 1'b1;
    cyc(2);
    chk("t3_ch0_wins", 32'(active_ch), 32'd0);
    pat = 32'd0;
    for (int i = 0; i < 16; i++) begin
      pat = {pat[30:0], piezo_out};
      cyc(1);
    end
    chk("t3_ch0_pattern", pat, 32'h0000_E38E);
    cyc(12);
    ch_en[0] = 1'b0;
    cyc(2);
    chk("t3_ch3_resumes", 32'(active_ch), 32'd3);
    pat = 32'd0;
    for (int i = 0; i < 16; i++) begin
      pat = {pat[30:0], piezo_out};
      cyc(1);
    end
    chk("t3_ch3_phase", pat, 32'h0000_0F0F);
    ch_en[3] = 1'b0;
    cyc(3);

    // Ch1 period change 8 -> 12 takes effect only at the wrap
    set_ch(1, 8, 0, 0, 1'b0);
    ch_en[1] = 1'b1;
    cyc(2);
    pat = 32'd0;
    for (int i = 0; i < 21; i++) begin
      pat = {pat[30:0], piezo_out};
      if (i == 1) ch_period[1*PERIOD_W +: PERIOD_W] = PERIOD_W'(12);
      cyc(1);
    end
    chk("t4_period_change", pat, 32'h001E_1F81);
    ch_en[1] = 1'b0;
    cyc(3);

    // Silent winner: ch1 period 1, then k=7, with ch2 active behind it
    set_ch(1, 1, 0, 0, 1'b0);
    set_ch(2, 4, 0, 0, 1'b0);
    ch_en[1] = 1'b1;
    ch_en[2] = 1'b1;
    cyc(2);
    chk("t5_ch_p1", 32'(active_ch), 32'd1);
    np = 0;
    for (int i = 0; i < 8; i++) begin
      if (piezo_out === 1'b1) np++;
      cyc(1);
    end
    chk("t5_silent_p1", 32'(np), 32'd0);
    set_ch(1, 8, 7, 0, 1'b0);
    cyc(2);
    np = 0;
    for (int i = 0; i < 8; i++) begin
      if (piezo_out === 1'b1) np++;
      cyc(1);
    end
    chk("t5_silent_k7", 32'(np), 32'd0);
    chk("t5_ch_k7", 32'(active_ch), 32'd1);
    ch_en[1] = 1'b0;
    cyc(2);
    chk("t5_ch2_wins", 32'(active_ch), 32'd2);
    np = 0;
    for (int i = 0; i < 8; i++) begin
      if (piezo_out === 1'b1) np++;
      cyc(1);
    end
    chk("t5_ch2_high", 32'(np), 32'd4);

    // Mute: one-cycle latency, status outputs unaffected
    mute = 1'b1;
    cyc(1);
    np = 0;
    for (int i = 0; i < 8; i++) begin
      if (piezo_out === 1'b1) np++;
      cyc(1);
    end
    chk("t5_mute_piezo", 32'(np), 32'd0);
    chk("t5_mute_any", 32'(any_active), 32'd1);
    chk("t5_mute_ch", 32'(active_ch), 32'd2);
    mute = 1'b0;
    cyc(1);
    np = 0;
    for (int i = 0; i < 8; i++) begin
      if (piezo_out === 1'b1) np++;
      cyc(1);
    end
    chk("t5_unmute_high", 32'(np), 32'd4);
    ch_en[2] = 1'b0;
    cyc(3);

    // Asynchronous reset in the middle of a long burst
    set_ch(2, 10, 0, 200, 1'b1);
    ch_trig[2] = 1'b1;
    cyc(1);
    ch_trig[2] = 1'b0;
    cyc(100);
    chk("t6_mid_burst", 32'(any_active), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_piezo", 32'(piezo_out), 32'd0);
    chk("t6_async_any", 32'(any_active), 32'd0);
    chk("t6_async_ch", 32'(active_ch), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
    chk("t6_stays_idle_any", 32'(any_active), 32'd0);
    chk("t6_stays_idle_ch", 32'(active_ch), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
